wb_arbiter: RTL and testbench

Write-back arbiter that owns the general register file's single write port (`we`/`waddr`/`wdata`). It merges the in-order MEM/WB result with results from the long-latency unit (divider/multiplier) through a 2-entry pending FIFO. It also performs load-data alignment and extension and drops writes to x0. It sits between the MEM/WB pipeline register and the register file; its outputs connect directly to the register file write port.

---
 rtl/wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register file write-port arbiter: MEM/WB commits vs. 2-entry long-latency FIFO
// Optional load formatting enabled by defining WB_LOAD_ALIGN_EN.
module wb_arbiter #(
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_load_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [1:0]  mem_addr_lo_i,
  input  logic [31:0] load_data_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        stall_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);

  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

  logic [4:0]  r_fifo_waddr [2];
  logic [31:0] r_fifo_wdata [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [3:0]  r_age;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  logic        w_nonempty;
  logic        w_full;
  logic [4:0]  w_head_waddr;
  logic [4:0]  w_tail_waddr;
  logic [31:0] w_head_wdata;
  logic        w_stall;
  logic        w_commit;
  logic        w_grant_head;
  logic        w_lu_ready;
  logic        w_lu_keep;
  logic        w_head_kill;
  logic        w_tail_kill;
  logic        w_rd_ptr_n;
  logic        w_wr_ptr_n;
  logic        w_enq_ptr;
  logic [1:0]  w_count_n;
  logic [31:0] w_load_data;
  logic [31:0] w_pipe_wdata;

`ifdef WB_LOAD_ALIGN_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = load_data_i[{mem_addr_lo_i, 3'b000} +: 8];
    w_half = mem_addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];
    case (mem_funct3_i)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = load_data_i;
    endcase
  end
`else
  logic w_unused_fmt;

  // Memory stage delivers pre-formatted load data in this build.
  assign w_load_data  = load_data_i;
  assign w_unused_fmt = ^{mem_funct3_i, mem_addr_lo_i};
`endif

  assign w_pipe_wdata = mem_load_i ? w_load_data : mem_wdata_i;

  assign w_nonempty   = (r_count != 2'd0);
  assign w_full       = (r_count == 2'd2);
  assign w_head_waddr = r_fifo_waddr[r_rd_ptr];
  assign w_tail_waddr = r_fifo_waddr[~r_rd_ptr];
  assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

  assign w_stall      = !rst && w_nonempty && (r_age >= AGE_LIM);
  assign w_commit     = mem_valid_i && mem_we_i && !w_stall && (mem_waddr_i != 5'd0);
  assign w_grant_head = w_stall || (!w_commit && w_nonempty);
  assign w_lu_ready   = !rst && (!w_full || w_grant_head);

  // A pipeline commit is younger than anything in the FIFO, so matching entries are dead.
  assign w_head_kill  = w_commit && w_nonempty && (w_head_waddr == mem_waddr_i);
  assign w_tail_kill  = w_commit && w_full && (w_tail_waddr == mem_waddr_i);
  assign w_lu_keep    = lu_valid_i && w_lu_ready && (lu_waddr_i != 5'd0) &&
                        !(w_commit && (lu_waddr_i == mem_waddr_i));

  always_comb begin
    w_rd_ptr_n = r_rd_ptr;
    w_wr_ptr_n = r_wr_ptr;
    w_count_n  = r_count;
    if (w_grant_head) begin
      w_rd_ptr_n = ~r_rd_ptr;
      w_count_n  = r_count - 2'd1;
    end else if (w_head_kill && w_tail_kill) begin
      w_count_n  = 2'd0;
    end else if (w_head_kill) begin
      w_rd_ptr_n = ~r_rd_ptr;
      w_count_n  = r_count - 2'd1;
    end else if (w_tail_kill) begin
      w_wr_ptr_n = ~r_wr_ptr;
      w_count_n  = r_count - 2'd1;
    end
    w_enq_ptr = w_wr_ptr_n;
    if (w_lu_keep) begin
      w_wr_ptr_n = ~w_wr_ptr_n;
      w_count_n  = w_count_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_rd_ptr <= w_rd_ptr_n;
      r_wr_ptr <= w_wr_ptr_n;
      r_count  <= w_count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_lu_keep) begin
      r_fifo_waddr[w_enq_ptr] <= lu_waddr_i;
      r_fifo_wdata[w_enq_ptr] <= lu_wdata_i;
    end
  end

  // Age restarts for every new head, so each entry gets its own AGE_MAX window.
  always_ff @(posedge clk) begin
    if (rst || w_grant_head || w_head_kill) begin
      r_age <= 4'd0;
    end else if (w_commit && w_nonempty && (r_age != 4'd15)) begin
      r_age <= r_age + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_grant_head) begin
      r_we    <= 1'b1;
      r_waddr <= w_head_waddr;
      r_wdata <= w_head_wdata;
    end else if (w_commit) begin
      r_we    <= 1'b1;
      r_waddr <= mem_waddr_i;
      r_wdata <= w_pipe_wdata;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign lu_ready_o = w_lu_ready;
  assign stall_o    = w_stall;
  assign we_o       = r_we;
  assign waddr_o    = r_waddr;
  assign wdata_o    = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (queue-based reference model)
// Load expectations follow WB_LOAD_ALIGN_EN.
module tb_wb_arbiter;

  localparam int AGE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_we_i, mem_load_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i, load_data_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic        lu_valid_i, lu_ready_o;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        stall_o, we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  wb_arbiter #(.AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i), .mem_load_i(mem_load_i), .mem_funct3_i(mem_funct3_i),
    .mem_addr_lo_i(mem_addr_lo_i), .load_data_i(load_data_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_waddr_i(lu_waddr_i),
    .lu_wdata_i(lu_wdata_i), .stall_o(stall_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [31:0] aligned;
  } ld_vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q[$];
  int          m_age = 0;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  logic        s_stall, s_ready;
  ld_vec_t     lv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] d);
    logic [31:0] b, h, r;
    b = (d >> (8 * lo)) & 32'hFF;
    h = (d >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  r = (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'b001:  r = (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'b100:  r = b;
      3'b101:  r = h;
      default: r = d;
    endcase
`ifdef WB_LOAD_ALIGN_EN
    return r;
`else
    return (r == r) ? d : d;
`endif
  endfunction

  task automatic idle();
    mem_valid_i = 0; mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0; mem_load_i = 0;
    mem_funct3_i = 0; mem_addr_lo_i = 0; load_data_i = 0;
    lu_valid_i = 0; lu_waddr_i = 0; lu_wdata_i = 0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    mem_valid_i = 1; mem_we_i = 1; mem_waddr_i = a; mem_wdata_i = d; mem_load_i = 0;
  endtask

  task automatic lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid_i = 1; lu_waddr_i = a; lu_wdata_i = d;
  endtask

  // One clock: model decides the grant from the queue, compares combinational outputs,
  // then compares the registered write after the edge.
  task automatic cycle();
    bit m_stall, commit, g_head, m_ready, was_rst;
    ent_t nq[$];
    #3;
    s_stall = stall_o;
    s_ready = lu_ready_o;
    was_rst = rst;
    if (rst) begin
      m_stall = 0; m_ready = 0;
      exp_we = 0; exp_wa = 0; exp_wd = 0;
      q.delete(); m_age = 0;
    end else begin
      m_stall = (q.size() > 0) && (m_age >= AGE_MAX);
      commit  = mem_valid_i && mem_we_i && !m_stall && (mem_waddr_i != 0);
      g_head  = (q.size() > 0) && (m_stall || !commit);
      m_ready = (q.size() < 2) || g_head;
      if (g_head) begin
        exp_we = 1; exp_wa = q[0].a; exp_wd = q[0].d;
        void'(q.pop_front());
        m_age = 0;
      end else if (commit) begin
        exp_we = 1; exp_wa = mem_waddr_i;
        exp_wd = mem_load_i ? fmt(mem_funct3_i, mem_addr_lo_i, load_data_i) : mem_wdata_i;
        if (q.size() > 0) begin
          if (q[0].a == mem_waddr_i) m_age = 0;
          else if (m_age < 15) m_age++;
        end
        foreach (q[i]) if (q[i].a != mem_waddr_i) nq.push_back(q[i]);
        q = nq;
      end else begin
        exp_we = 0;
      end
      if (lu_valid_i && m_ready && lu_waddr_i != 0 && !(commit && lu_waddr_i == mem_waddr_i))
        q.push_back('{a: lu_waddr_i, d: lu_wdata_i});
    end
    chk("stall_o", s_stall, m_stall);
    chk("lu_ready_o", s_ready, m_ready);
    @(posedge clk);
    #1;
    chk("we_o", we_o, exp_we);
    if (exp_we || was_rst) begin
      chk("waddr_o", waddr_o, exp_wa);
      chk("wdata_o", wdata_o, exp_wd);
    end
  endtask

  initial begin
    lv[0]  = '{3'b000, 2'd3, 32'h80FF0000, 32'hFFFFFF80};
    lv[1]  = '{3'b101, 2'd2, 32'h80FF0000, 32'h000080FF};
    lv[2]  = '{3'b001, 2'd2, 32'h80FF0000, 32'hFFFF80FF};
    lv[3]  = '{3'b100, 2'd2, 32'h80FF0000, 32'h000000FF};
    lv[4]  = '{3'b000, 2'd2, 32'h80FF0000, 32'hFFFFFFFF};
    lv[5]  = '{3'b010, 2'd0, 32'h80FF0000, 32'h80FF0000};
    lv[6]  = '{3'b001, 2'd1, 32'h80FF0000, 32'h00000000};
    lv[7]  = '{3'b011, 2'd1, 32'h80FF0000, 32'h80FF0000};
    lv[8]  = '{3'b000, 2'd1, 32'h12345678, 32'h00000056};
    lv[9]  = '{3'b100, 2'd0, 32'h12345678, 32'h00000078};
    lv[10] = '{3'b001, 2'd3, 32'h12345678, 32'h00001234};

    rst = 1;
    idle();
    cycle();
    cycle();
    chk("reset_we", we_o, 0);
    chk("reset_waddr", waddr_o, 0);
    chk("reset_wdata", wdata_o, 0);
    chk("reset_ready", s_ready, 0);
    rst = 0;

    pipe(5, 32'h12345678);
    cycle();
    chk("commit_we", we_o, 1);
    chk("commit_waddr", waddr_o, 5);
    chk("commit_wdata", wdata_o, 32'h12345678);
    idle();
    cycle();
    chk("commit_done", we_o, 0);

    for (int i = 0; i < 11; i++) begin
      idle();
      pipe(5'(i + 1), 32'hBAD0BAD0);
      mem_load_i = 1; mem_funct3_i = lv[i].f3; mem_addr_lo_i = lv[i].lo;
      load_data_i = lv[i].d;
      cycle();
`ifdef WB_LOAD_ALIGN_EN
      chk("load_fmt", wdata_o, lv[i].aligned);
`else
      chk("load_raw", wdata_o, lv[i].d);
`endif
    end

    idle();
    lu(7, 32'hA);
    cycle();
    chk("lu_accept", s_ready, 1);
    idle();
    cycle();
    chk("lu_we", we_o, 1);
    chk("lu_waddr", waddr_o, 7);
    chk("lu_wdata", wdata_o, 32'hA);
    cycle();

    lu(9, 32'h99);
    cycle();
    idle();
    for (int i = 0; i < AGE_MAX; i++) begin
      pipe(5'(10 + i), 32'h1000 + i);
      cycle();
      chk("age_no_stall", s_stall, 0);
      chk("age_pipe_waddr", waddr_o, 10 + i);
    end
    pipe(20, 32'h2020);
    cycle();
    chk("age_stall", s_stall, 1);
    chk("age_head_waddr", waddr_o, 9);
    chk("age_head_wdata", wdata_o, 32'h99);
    cycle();
    chk("age_release", s_stall, 0);
    chk("held_waddr", waddr_o, 20);
    chk("held_wdata", wdata_o, 32'h2020);
    idle();
    cycle();

    pipe(20, 32'h20); lu(3, 32'hDEAD0003);
    cycle();
    pipe(21, 32'h21); lu(4, 32'hBEEF0004);
    cycle();
    idle();
    pipe(3, 32'h33);
    cycle();
    chk("full_not_ready", s_ready, 0);
    chk("squash_pipe_waddr", waddr_o, 3);
    chk("squash_pipe_wdata", wdata_o, 32'h33);
    idle();
    cycle();
    chk("squash_ready", s_ready, 1);
    chk("squash_drain_waddr", waddr_o, 4);
    chk("squash_drain_wdata", wdata_o, 32'hBEEF0004);
    cycle();
    chk("squash_empty", we_o, 0);

    pipe(0, 32'h55); lu(0, 32'h66);
    cycle();
    chk("x0_lu_ready", s_ready, 1);
    chk("x0_we", we_o, 0);
    idle();
    cycle();
    chk("x0_we_later", we_o, 0);

    pipe(12, 32'h1212); lu(12, 32'hC0C0);
    cycle();
    chk("waw_pipe_waddr", waddr_o, 12);
    idle();
    cycle();
    chk("waw_lu_dropped", we_o, 0);

    pipe(13, 32'h13); lu(5, 32'h55);
    cycle();
    pipe(14, 32'h14); lu(6, 32'h66);
    cycle();
    idle();
    rst = 1;
    cycle();
    chk("midrst_we", we_o, 0);
    rst = 0;
    cycle();
    chk("midrst_flushed", we_o, 0);

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      mem_valid_i   = ($urandom_range(0, 3) != 0);
      mem_we_i      = ($urandom_range(0, 7) != 0);
      mem_waddr_i   = 5'($urandom_range(0, 7));
      mem_wdata_i   = $urandom;
      mem_load_i    = ($urandom_range(0, 2) == 0);
      mem_funct3_i  = 3'($urandom);
      mem_addr_lo_i = 2'($urandom);
      load_data_i   = $urandom;
      lu_valid_i    = 1'($urandom);
      lu_waddr_i    = 5'($urandom_range(0, 7));
      lu_wdata_i    = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
